// File: rtl/cnt_arb_pkg.sv
// Shared types and widths for the counter-sharing arbiter.
// Holds the arbiter state enum and the counter/hold-counter widths.
package cnt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    localparam int CNT_W  = 8;
    localparam int HOLD_W = 8;

endpackage

// File: rtl/cnt_share_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning up from last_id+1.
// Ports: req, last_id in; win (one-hot), win_id, valid out.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_id,
    output logic [NREQ-1:0] win,
    output logic [IDW-1:0]  win_id,
    output logic            valid
);

    logic [IDW-1:0] idx;

    // Scan from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        win    = '0;
        win_id = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last_id) + k) % NREQ);
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
                win_id   = idx;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_share_arb.sv
// Round-robin owner of the shared 8-bit counter: grants, clears and enables it.
// Ports: clk, rst_n, req in; gnt, gnt_id, busy, cnt_clr, cnt_en, preempt out.
// Optional tenure quota and preempt pulse: define CNT_ARB_TIMEOUT_EN.
module cnt_share_arb
    import cnt_arb_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            cnt_clr,
    output logic            cnt_en,
    output logic            preempt
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("cnt_share_arb: NREQ must be 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("cnt_share_arb: MAX_HOLD must be 1..255");
    end

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [IDW-1:0]    last_id;
    logic [NREQ-1:0]   pick_oh;
    logic [IDW-1:0]    pick_id;
    logic              pick_vld;
    logic              own_req;
    logic              quota_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req),
        .last_id (last_id),
        .win     (pick_oh),
        .win_id  (pick_id),
        .valid   (pick_vld)
    );

    assign own_req  = req[gnt_id];
    assign hold_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;

`ifdef CNT_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    // hold_cnt is 0 in the cnt_clr cycle, so this ends the tenure
    // after exactly MAX_HOLD grant cycles.
    assign quota_hit = (hold_cnt == HOLD_LAST);
`else
    assign quota_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_en   <= 1'b0;
            preempt  <= 1'b0;
            last_id  <= IDW'(NREQ - 1);
            hold_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    preempt <= 1'b0;
                    if (pick_vld) begin
                        state    <= GRANT;
                        gnt      <= pick_oh;
                        gnt_id   <= pick_id;
                        last_id  <= pick_id;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        cnt_clr  <= 1'b1;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_nxt;
                    cnt_clr  <= 1'b0;
                    if (!own_req || quota_hit) begin
                        state   <= GAP;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        cnt_en  <= 1'b0;
                        // A release in the quota cycle wins over the timeout.
                        preempt <= own_req & quota_hit;
                    end else begin
                        cnt_en <= 1'b1;
                    end
                end
                GAP: begin
                    preempt <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_share_arb.sv
// Self-checking bench for cnt_share_arb against a tenure-level reference model.
// Optional timeout scenario runs when CNT_ARB_TIMEOUT_EN is defined.
module tb_cnt_share_arb;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 16;
    localparam int IDW      = 2;
`ifdef CNT_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            busy;
    logic            cnt_clr;
    logic            cnt_en;
    logic            preempt;
    logic [9:0]      obs;
    logic [7:0]      tb_cnt;

    int n_vec = 0;
    int n_err = 0;

    cnt_share_arb #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, gnt_id, busy, cnt_clr, cnt_en, preempt};

    // Stand-in for the shared counter driven by the arbiter.
    always @(posedge clk) begin
        if (cnt_clr) tb_cnt <= 8'd0;
        else if (cnt_en) tb_cnt <= tb_cnt + 8'd1;
    end

    // Reference model: who owns the counter, for how many cycles so far,
    // whether a dead cycle is pending, and who owned it last.
    int m_owner;
    int m_held;
    int m_cool;
    int m_last;
    int m_id;
    bit m_pre;

    function automatic void m_reset();
        m_owner = -1;
        m_held  = 0;
        m_cool  = 0;
        m_last  = NREQ - 1;
        m_id    = 0;
        m_pre   = 1'b0;
    endfunction

    function automatic void m_step(input logic [NREQ-1:0] r);
        logic [NREQ-1:0] oh;
        bit rel;
        bit tmo;
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            oh  = NREQ'(1) << m_owner;
            rel = ((r & oh) == '0);
            tmo = TMO && (m_held >= MAX_HOLD);
            if (rel || tmo) begin
                m_pre   = !rel;
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool > 0) begin
            m_cool = 0;
        end else if (r != '0) begin
            for (int k = 1; k <= NREQ && m_owner < 0; k++) begin
                oh = NREQ'(1) << ((m_last + k) % NREQ);
                if ((r & oh) != '0) m_owner = (m_last + k) % NREQ;
            end
            m_last = m_owner;
            m_id   = m_owner;
            m_held = 0;
        end
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [NREQ-1:0] g;
        bit own;
        own = (m_owner >= 0);
        g   = own ? (NREQ'(1) << m_owner) : '0;
        return {g, IDW'(m_id), own, own && m_held == 0,
                own && m_held > 0, m_pre};
    endfunction

    // Drive req for one cycle; model follows the edge; return at negedge.
    task automatic cyc(input logic [NREQ-1:0] r);
        req = r;
        @(posedge clk);
        m_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '1;
        m_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (obs !== 10'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", obs);
        end
        rst_n = 1'b1;
        cyc(4'b1111);
        n_vec++;
        if (gnt !== 4'b0001 || obs !== exp_vec()) begin
            n_err++;
            $display("FAIL first_grant: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        int clr_n;
        int en_n;
        clr_n = 0;
        en_n  = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0100);
            clr_n += int'(cnt_clr);
            en_n  += int'(cnt_en);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL single c%0d: got %b want %b", i, obs, exp_vec());
            end
        end
        cyc(4'b0000);
        n_vec++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || cnt_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: got %b want gnt=0", obs);
        end
        n_vec++;
        if (clr_n != 1 || en_n != 9) begin
            n_err++;
            $display("FAIL single_counts: got clr=%0d en=%0d want 1/9", clr_n, en_n);
        end
        n_vec++;
        if (tb_cnt !== 8'd9) begin
            n_err++;
            $display("FAIL single_count_value: got %0d want 9", tb_cnt);
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int held;
        int gap;
        logic [NREQ-1:0] r;
        held = 0;
        gap  = 0;
        r    = '1;
        do_reset();
        for (int i = 0; i < 60 && order.size() < 5; i++) begin
            cyc(r);
            r = '1;
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL rotation c%0d: got %b want %b", i, obs, exp_vec());
            end
            if (busy) begin
                if (cnt_clr) begin
                    if (order.size() > 0) begin
                        n_vec++;
                        if (gap != 2) begin
                            n_err++;
                            $display("FAIL rotation_gap: got %0d want 2", gap);
                        end
                    end
                    order.push_back(int'(gnt_id));
                end
                held++;
                gap = 0;
                if (held == 3) r = ~gnt;
            end else begin
                held = 0;
                gap++;
            end
        end
        n_vec++;
        if (order.size() != 5) begin
            n_err++;
            $display("FAIL rotation_bound: got %0d grants want 5", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            n_vec++;
            if (order[k] != k % NREQ) begin
                n_err++;
                $display("FAIL rotation_order[%0d]: got %0d want %0d", k, order[k], k % NREQ);
            end
        end
    endtask

`ifdef CNT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n0;
        int n_pre;
        int second;
        n0     = 0;
        n_pre  = 0;
        second = -1;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            cyc(4'b0011);
            if (gnt === 4'b0001) n0++;
            if (preempt === 1'b1) n_pre++;
            if (cnt_clr === 1'b1 && i > 0 && second < 0) second = int'(gnt_id);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL timeout c%0d: got %b want %b", i, obs, exp_vec());
            end
        end
        n_vec++;
        if (n0 != MAX_HOLD || n_pre != 1 || second != 1) begin
            n_err++;
            $display("FAIL timeout_summary: got hold=%0d pre=%0d next=%0d want %0d/1/1",
                     n0, n_pre, second, MAX_HOLD);
        end
    endtask
`else
    task automatic test_no_timeout();
        int n_hi;
        int n_pre;
        n_hi  = 0;
        n_pre = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(4'b0001);
            if (gnt === 4'b0001) n_hi++;
            if (preempt !== 1'b0) n_pre++;
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL no_timeout c%0d: got %b want %b", i, obs, exp_vec());
            end
        end
        n_vec++;
        if (n_hi != 300 || n_pre != 0) begin
            n_err++;
            $display("FAIL no_timeout_summary: got hi=%0d pre=%0d want 300/0", n_hi, n_pre);
        end
    endtask
`endif

    task automatic test_clr_drop();
        int en_n;
        int busy_n;
        en_n   = 0;
        busy_n = 0;
        do_reset();
        cyc(4'b0010);
        busy_n += int'(busy);
        n_vec++;
        if (cnt_clr !== 1'b1 || gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL clr_drop_grant: got %b want gnt=0010 clr=1", obs);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000);
            en_n   += int'(cnt_en);
            busy_n += int'(busy);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL clr_drop c%0d: got %b want %b", i, obs, exp_vec());
            end
        end
        n_vec++;
        if (en_n != 0 || busy_n != 1) begin
            n_err++;
            $display("FAIL clr_drop_summary: got en=%0d busy=%0d want 0/1", en_n, busy_n);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1000);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL async_pre c%0d: got %b want %b", i, obs, exp_vec());
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 10'd0) begin
            n_err++;
            $display("FAIL async_reset: got %b want 0", obs);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1000);
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL async_regrant: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        r = '0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            cyc(r);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random c%0d: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
`ifdef CNT_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_clr_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cnt_share_arb.md
# cnt_share_arb

Round-robin arbiter and sequencer that shares the single 8-bit free-running counter datapath among `NREQ` requesters. It grants one requester at a time and drives the counter's clear and enable controls, so each owner sees the count start from 0 at the beginning of its tenure. The block sits between the requesting control blocks and the counter instance. It is the only block that drives the counter's control inputs.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `MAX_HOLD`, 16: maximum grant tenure in cycles when timeout is compiled in; legal range 1..255.
- `IDW`, $clog2(NREQ): width of `gnt_id`; derived, not overridden.

Ports:
- `clk`  in  1  single system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset; deassertion is synchronous to `clk` by the caller.
- `req`  in  NREQ  level request, one bit per requester; held high for as long as the requester wants ownership.
- `gnt`  out  NREQ  one-hot registered grant; all zero when no one owns the counter.
- `gnt_id`  out  IDW  index of the current owner; holds the last owner when `gnt` is zero.
- `busy`  out  1  high whenever `gnt` is nonzero.
- `cnt_clr`  out  1  one-cycle pulse on the first cycle of each grant; clears the counter.
- `cnt_en`  out  1  high on every grant cycle except the `cnt_clr` cycle.
- `preempt`  out  1  one-cycle pulse when a grant is revoked by timeout; tied 0 without `CNT_ARB_TIMEOUT_EN`.

## Operation
- The FSM has three states: IDLE, GRANT and GAP. Reset state is IDLE.
- **IDLE:**
  - If `req` is nonzero, pick a winner and go to GRANT.
  - The winner is the first set bit scanning upward from `last_id+1`, wrapping modulo `NREQ`.
  - On that transition, register `gnt`, `gnt_id`, `last_id` and `hold_cnt`=0, and assert `cnt_clr`.
- **GRANT:**
  - `hold_cnt` increments each cycle and saturates at 255.
  - If `req[gnt_id]` is low, go to GAP.
  - With timeout compiled in: if `hold_cnt`==`MAX_HOLD`-1 and `req[gnt_id]` is still high, go to GAP and pulse `preempt`.
- **GAP:** one dead cycle in which `gnt`=0, `cnt_en`=0 and `cnt_clr`=0. Always returns to IDLE.
- Fairness:
  - Because `last_id` is updated at grant time, the previous owner has lowest priority in the next arbitration.
  - A preempted requester that keeps `req` high re-enters arbitration normally and wins again only if no other request is pending.
- Requests from non-owners during GRANT or GAP are ignored until IDLE. No request is queued or latched.
- Reset values: `gnt`=0, `gnt_id`=0, `busy`=0, `cnt_clr`=0, `cnt_en`=0, `preempt`=0, `last_id`=`NREQ`-1 (so requester 0 wins first), `hold_cnt`=0.
- Reset asserted mid-grant drops every output to its reset value immediately. No `preempt` pulse is produced.

## Timing
- Grant latency:
  - `req` is sampled high in IDLE at edge t.
  - `gnt`/`busy`/`cnt_clr` are high in cycle t+1.
  - `cnt_en` rises in cycle t+2.
- Release:
  - `req[gnt_id]` is sampled low at edge t.
  - `gnt`, `busy` and `cnt_en` are low in cycle t+1 (GAP).
  - IDLE is reached at t+2. The next grant appears at t+3 at the earliest.
- A requester that drops `req` in the same cycle that `cnt_clr` is asserted is released after exactly one grant cycle. `cnt_en` never rises in that case.
- Timeout: a grant lasts exactly `MAX_HOLD` cycles, including the `cnt_clr` cycle. `preempt` is high in the first GAP cycle. With `MAX_HOLD`=1, `cnt_en` never asserts.
- If release and timeout coincide, the grant is treated as a release and `preempt` stays 0.
- Minimum spacing between grants is 2 idle cycles (GAP plus IDLE).
- All outputs are registered. There is no combinational path from `req` to any output.

## Configuration
- `CNT_ARB_TIMEOUT_EN`, when defined:
  - `MAX_HOLD` quota enforcement and the `preempt` pulse are compiled in.
- When undefined:
  - A grant is held until the owner drops `req`.
  - `preempt` is constant 0.
  - `hold_cnt` is still kept for debug.
  - `MAX_HOLD` is ignored.

## Structure
- Package `cnt_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT, GAP);
  - the counter width constant `CNT_W`=8;
  - the hold counter width constant `HOLD_W`=8.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` and `last_id`.
  - Outputs: a one-hot winner, the winner index and a valid flag.
  - It is instantiated once; the FSM and registers stay in `cnt_share_arb`.

## Test plan
- **Reset:** assert `rst_n`=0 for 3 cycles with `req`=4'b1111 → all outputs 0. The first grant after release goes to requester 0, with `gnt`=4'b0001.
- **Single owner:** `req`=4'b0100 for 10 cycles, then drop it.
  - `cnt_clr` is high for 1 cycle, then `cnt_en` is high for 9 cycles.
  - `gnt` is low 1 cycle after the drop.
  - The counter reads 9 at release.
- **Rotation:** hold `req`=4'b1111; each owner drops and re-raises `req` after 3 cycles → grant order 0,1,2,3,0 with a 2-cycle gap between grants.
- **Timeout** (macro on, `MAX_HOLD`=16): hold `req`=4'b0011 → requester 0 holds `gnt` for exactly 16 cycles, `preempt` pulses once, and the next grant is to requester 1.
- **No timeout** (macro off): `req`=4'b0001 held for 300 cycles → `gnt` stays high for the whole duration, and `preempt` is never asserted.
- **Corner cases:**
  - Owner drops `req` in the `cnt_clr` cycle → 1-cycle grant, and `cnt_en` never rises.
  - Reset pulse mid-grant → outputs are 0 asynchronously within the same cycle.
